down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Loadable down-counter/timer; the decrementing counterpart of the team's 8-bit up-counter with overflow flag.
- Counts from a programmed value toward zero and flags underflow with UF, mirroring the up-counter's OV.
- Supports one-shot and auto-reload modes.
- Drives timeout and period generation in the same datapath as the up-counter; clk/Reset/EN/CLR semantics match it except for reset polarity.

Parameters:
WIDTH, 8, counter and load-value width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous reset, active-high; clears all state immediately
EN  input  1  count enable; decrement when high in RUN
CLR  input  1  synchronous clear to IDLE
LOAD  input  1  synchronous load strobe
load_value  input  WIDTH  start/reload value, sampled when LOAD=1
AUTO  input  1  1 = auto-reload on underflow, 0 = one-shot
counter  output  WIDTH  current count (registered)
UF  output  1  underflow pulse, registered, high one cycle
busy  output  1  high while state is RUN (decoded from state register)
done  output  1  high while state is EXPIRED

Behaviour:
- Reset=1 (asynchronous, any time, including mid-count):
  - counter=0, reload register=0, UF=0, state=IDLE, so busy=0 and done=0.
  - No other input has effect while Reset=1.
- Priority each rising edge: CLR > LOAD > EN.
- State machine has three states: IDLE, RUN, EXPIRED.
- IDLE:
  - EN ignored; counter holds.
  - LOAD -> counter<=load_value, reload<=load_value, go RUN.
- RUN:
  - EN=0: counter holds, state holds (pause).
  - EN=1, counter!=0: counter<=counter-1.
  - EN=1, counter==0: UF<=1 for the next cycle.
    - AUTO=1: counter<=reload, stay RUN.
    - AUTO=0: counter stays 0, go EXPIRED.
  - LOAD (with or without EN): counter<=load_value, reload<=load_value, stay RUN, no decrement that cycle, no UF.
- EXPIRED:
  - done=1; EN ignored; counter=0.
  - LOAD -> reload, go RUN (done drops next cycle).
- CLR in any state: counter<=0, state<=IDLE, UF<=0. Reload register is kept.
- UF timing:
  - Asserted in the cycle after the decrement-at-zero edge.
  - Cleared on every other edge, so it is never high two consecutive cycles unless reload=0 with AUTO=1.
- Loading 0:
  - Go RUN; first enabled edge underflows immediately.
  - With AUTO=1 and reload=0, UF stays high every enabled cycle.
- Period: with AUTO=1 and EN held high, the UF period is reload+1 cycles.
- AUTO is sampled only at the underflow edge; changing it mid-count is legal.
- Arithmetic is unsigned modulo 2^WIDTH. No decrement ever occurs below 0: at zero the counter either reloads or stops.
- Simultaneous LOAD and underflow: LOAD wins, no UF.
- Simultaneous CLR and LOAD: CLR wins, state IDLE, reload unchanged.

Test Plan:
1. Reset=1 for 2 cycles, then 0; EN=1, no LOAD -> counter=0x00, busy=0, done=0, UF=0 throughout; state stays IDLE.
2. LOAD with load_value=0x03, AUTO=0, EN=1 -> counter 3,2,1,0 on successive edges.
   - UF high exactly one cycle after the zero edge.
   - done=1 and busy=0 thereafter; counter stays 0x00 for 10 more cycles.
3. LOAD 0x02, AUTO=1, EN=1 for 12 cycles -> counter 2,1,0,2,1,0,...; UF pulses every 3 cycles; busy stays 1.
4. LOAD 0x05, EN=1 for 2 edges, EN=0 for 4 edges, EN=1 -> counter 5,4,3 holds at 3 during pause, then 2,1,0; UF fires once.
5. Simultaneous events:
   - LOAD 0x10 on the same edge counter==0 with EN=1 -> counter=0x10, no UF.
   - CLR+LOAD on the same edge -> counter=0, IDLE, a later LOAD-free EN does nothing.
6. Reset asserted asynchronously mid-count (counter=0x07, between edges) -> outputs zero immediately, before the next edge. After deassert, state is IDLE until the next LOAD.

Source files
------------

// File: rtl/down_counter.sv
// down_counter -- loadable down-counter / timer with underflow flag.
//
// Counts from a programmed value toward zero. Reaching zero with EN high
// produces a one-cycle UF pulse; the counter then either reloads the last
// loaded value (AUTO=1, period = reload+1 cycles) or stops at zero and
// reports done (AUTO=0).
//
// Ports:
//   clk        in   system clock, all state updates on rising edge
//   Reset      in   asynchronous active-high reset, clears all state
//   EN         in   count enable (only acts in RUN)
//   CLR        in   synchronous clear to IDLE (reload value kept)
//   LOAD       in   synchronous load strobe, starts/restarts RUN
//   load_value in   start/reload value, sampled when LOAD=1
//   AUTO       in   1 = auto-reload on underflow, 0 = one-shot
//   counter    out  current count (registered)
//   UF         out  underflow pulse, registered, one cycle
//   busy       out  high while in RUN
//   done       out  high while in EXPIRED
//
// Edge priority: CLR > LOAD > EN.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] load_value,
  input  logic             AUTO,
  output logic [WIDTH-1:0] counter,
  output logic             UF,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] EXPIRED = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      counter <= '0;
      reload  <= '0;
      UF      <= 1'b0;
    end else begin
      // UF is a pulse: anything other than an underflow edge clears it.
      UF <= 1'b0;
      if (CLR) begin
        counter <= '0;
        state   <= IDLE;
      end else if (LOAD) begin
        // A load always wins over a same-edge underflow, so no UF here.
        counter <= load_value;
        reload  <= load_value;
        state   <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (EN) begin
              if (counter != '0) begin
                counter <= counter - WIDTH'(1);
              end else begin
                // At zero we never wrap: either reload or stop.
                UF <= 1'b1;
                if (AUTO) begin
                  counter <= reload;
                end else begin
                  state <= EXPIRED;
                end
              end
            end
          end
          EXPIRED: begin
            counter <= '0;
          end
          IDLE: begin
            // EN has no effect until something is loaded.
          end
          default: begin
            // Unreachable encoding: recover to a safe idle state.
            state   <= IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == EXPIRED);

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: the driver applies one directed vector
// per clock edge and queues the hand-computed response; an independent
// monitor pops each queued response and compares it with the DUT outputs.
module tb_down_counter;

  logic       clk;
  logic       Reset;
  logic       EN;
  logic       CLR;
  logic       LOAD;
  logic [7:0] load_value;
  logic       AUTO;
  logic [7:0] counter;
  logic       UF;
  logic       busy;
  logic       done;

  down_counter #(.WIDTH(8)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .EN         (EN),
    .CLR        (CLR),
    .LOAD       (LOAD),
    .load_value (load_value),
    .AUTO       (AUTO),
    .counter    (counter),
    .UF         (UF),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       uf;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector before the next rising edge, then queue its response.
  task automatic step(input logic rst, input logic en, input logic clr,
                      input logic load, input logic [7:0] lv, input logic auto,
                      input logic [7:0] ec, input logic euf, input logic eb,
                      input logic ed, input string nm);
    exp_t e;
    @(negedge clk);
    Reset      = rst;
    EN         = en;
    CLR        = clr;
    LOAD       = load;
    load_value = lv;
    AUTO       = auto;
    @(posedge clk);
    e.cnt  = ec;
    e.uf   = euf;
    e.busy = eb;
    e.done = ed;
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  // Monitor: compare each queued response shortly after it is expected.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      wait (q_exp.size() != 0);
      #1;
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      n_cmp++;
      if ({counter, UF, busy, done} !== e) begin
        n_fail++;
        $display("FAIL %s: got counter=%02h UF=%b busy=%b done=%b, expected counter=%02h UF=%b busy=%b done=%b",
                 nm, counter, UF, busy, done, e.cnt, e.uf, e.busy, e.done);
      end
    end
  end

  initial begin
    exp_t e;
    Reset = 1'b1; EN = 1'b1; CLR = 1'b0; LOAD = 1'b1;
    load_value = 8'h55; AUTO = 1'b0;

    // 1: reset holds everything, LOAD/EN ignored; then IDLE ignores EN.
    step(1, 1, 0, 1, 8'h55, 0, 8'h00, 0, 0, 0, "rst_hold0");
    step(1, 1, 0, 1, 8'h55, 0, 8'h00, 0, 0, 0, "rst_hold1");
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "idle_en");

    // 2: one-shot from 3.
    step(0, 1, 0, 1, 8'h03, 0, 8'h03, 0, 1, 0, "os_load3");
    step(0, 1, 0, 0, 8'h00, 0, 8'h02, 0, 1, 0, "os_cnt2");
    step(0, 1, 0, 0, 8'h00, 0, 8'h01, 0, 1, 0, "os_cnt1");
    step(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, "os_cnt0");
    step(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 1, "os_uf");
    for (int i = 0; i < 10; i++)
      step(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, "os_expired");

    // 3: auto-reload of 2, UF every 3 cycles.
    step(0, 1, 0, 1, 8'h02, 1, 8'h02, 0, 1, 0, "ar_load2");
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       step(0, 1, 0, 0, 8'h00, 1, 8'h01, 0, 1, 0, "ar_cnt1");
        1:       step(0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 1, 0, "ar_cnt0");
        default: step(0, 1, 0, 0, 8'h00, 1, 8'h02, 1, 1, 0, "ar_reload");
      endcase
    end

    // 4: pause with EN=0 mid-count (reload over a running auto count).
    step(0, 1, 0, 1, 8'h05, 0, 8'h05, 0, 1, 0, "pz_load5");
    step(0, 1, 0, 0, 8'h00, 0, 8'h04, 0, 1, 0, "pz_cnt4");
    step(0, 1, 0, 0, 8'h00, 0, 8'h03, 0, 1, 0, "pz_cnt3");
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 8'h00, 0, 8'h03, 0, 1, 0, "pz_hold3");
    step(0, 1, 0, 0, 8'h00, 0, 8'h02, 0, 1, 0, "pz_cnt2");
    step(0, 1, 0, 0, 8'h00, 0, 8'h01, 0, 1, 0, "pz_cnt1");
    step(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1, 0, "pz_cnt0");
    step(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 1, "pz_uf");
    step(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, "pz_uf_once");

    // 5a: LOAD on the underflow edge wins, no UF.
    step(0, 1, 0, 1, 8'h01, 1, 8'h01, 0, 1, 0, "sim_load1");
    step(0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 1, 0, "sim_cnt0");
    step(0, 1, 0, 1, 8'h10, 1, 8'h10, 0, 1, 0, "sim_load_vs_uf");
    step(0, 1, 0, 0, 8'h00, 1, 8'h0F, 0, 1, 0, "sim_after_load");

    // 5b: CLR beats LOAD; IDLE then ignores EN.
    step(0, 1, 1, 1, 8'h33, 1, 8'h00, 0, 0, 0, "sim_clr_load");
    step(0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, "sim_idle_en0");
    step(0, 1, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, "sim_idle_en1");

    // Loading 0: immediate underflow, continuous UF with AUTO=1.
    step(0, 1, 0, 1, 8'h00, 1, 8'h00, 0, 1, 0, "z_load0");
    step(0, 1, 0, 0, 8'h00, 1, 8'h00, 1, 1, 0, "z_uf_a");
    step(0, 1, 0, 0, 8'h00, 1, 8'h00, 1, 1, 0, "z_uf_b");
    step(0, 0, 0, 0, 8'h00, 1, 8'h00, 0, 1, 0, "z_pause");
    step(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0, 1, "z_uf_oneshot");

    // 6: asynchronous reset between edges mid-count.
    step(0, 0, 0, 1, 8'h07, 0, 8'h07, 0, 1, 0, "ar_load7");
    step(0, 0, 0, 0, 8'h00, 0, 8'h07, 0, 1, 0, "ar_hold7");
    #3;
    Reset = 1'b1;
    e.cnt = 8'h00; e.uf = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    q_exp.push_back(e);
    q_name.push_back("async_rst_now");
    step(1, 1, 0, 1, 8'h09, 0, 8'h00, 0, 0, 0, "async_rst_held");
    step(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "post_rst_idle0");
    step(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "post_rst_idle1");
    step(0, 1, 0, 1, 8'h04, 0, 8'h04, 0, 1, 0, "post_rst_load4");
    step(0, 1, 0, 0, 8'h00, 0, 8'h03, 0, 1, 0, "post_rst_cnt3");

    // Drain: every queued response must have been checked.
    repeat (3) @(posedge clk);
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked responses, expected 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
